// File: rtl/toy_rename_alloc_ctrl.sv
// -----------------------------------------------------------------------------
// toy_rename_alloc_ctrl
//
// Physical-register allocator for the rename map. Holds the circular free list
// of physical IDs. Grants up to RENAME_WIDTH destinations per cycle, and only
// when every lane that needs an ID can get one. Commit-time releases push
// superseded IDs back onto the list. A cancel rewinds the read pointer to the
// commit pointer, which returns every speculative allocation to the list.
//
// Pointers count modulo 2*FREE_DEPTH. The storage index is the pointer modulo
// FREE_DEPTH. With this scheme a full list and an empty list have different
// pointer values.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   alloc_req_vld       per-lane instruction valid
//   alloc_req_rd_en     per-lane destination present
//   alloc_req_arch_id   per-lane destination arch ID (lane k at [k*AW +: AW])
//   alloc_rdy           all valid lanes accepted this cycle (combinational)
//   alloc_phy_id        per-lane granted phy ID (lane k at [k*PRW +: PRW])
//   reg_rd_en           per-arch-entry map write enable
//   reg_rd_allocate_id  per-arch-entry new phy ID (entry a at [a*PRW +: PRW])
//   cancel_en           pipeline flush request
//   cancel_edge_en      restore-from-backup strobe to the map entries
//   commit_rd_en        per-commit-lane release valid
//   commit_old_phy_id   per-commit-lane superseded phy ID
//   free_cnt            registered free-list occupancy
// -----------------------------------------------------------------------------
module toy_rename_alloc_ctrl #(
  parameter  int RENAME_WIDTH     = 4,
  parameter  int COMMIT_WIDTH     = 4,
  parameter  int ARCH_REG_NUM     = 32,
  parameter  int PHY_REG_NUM      = 128,
  parameter  int PHY_REG_ID_WIDTH = 7,
  localparam int AW               = $clog2(ARCH_REG_NUM),
  localparam int PRW              = PHY_REG_ID_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [RENAME_WIDTH-1:0]        alloc_req_vld,
  input  logic [RENAME_WIDTH-1:0]        alloc_req_rd_en,
  input  logic [RENAME_WIDTH*AW-1:0]     alloc_req_arch_id,
  output logic                           alloc_rdy,
  output logic [RENAME_WIDTH*PRW-1:0]    alloc_phy_id,
  output logic [ARCH_REG_NUM-1:0]        reg_rd_en,
  output logic [ARCH_REG_NUM*PRW-1:0]    reg_rd_allocate_id,
  input  logic                           cancel_en,
  output logic                           cancel_edge_en,
  input  logic [COMMIT_WIDTH-1:0]        commit_rd_en,
  input  logic [COMMIT_WIDTH*PRW-1:0]    commit_old_phy_id,
  output logic [PRW:0]                   free_cnt
);

  localparam int FREE_DEPTH = PHY_REG_NUM - ARCH_REG_NUM;
  localparam int IW         = $clog2(FREE_DEPTH);
  localparam int PTRW       = IW + 1;
  localparam int CNTW       = PRW + 1;
  localparam int CW         = $clog2(RENAME_WIDTH + 1);
  localparam int MW         = $clog2(COMMIT_WIDTH + 1);

  localparam logic [PTRW:0] DEPTH_X = (PTRW+1)'(FREE_DEPTH);
  localparam logic [PTRW:0] WRAP_X  = (PTRW+1)'(2 * FREE_DEPTH);

  // Advance a pointer by n (n < FREE_DEPTH), wrapping at 2*FREE_DEPTH.
  function automatic logic [PTRW-1:0] ptr_add(input logic [PTRW-1:0] p,
                                               input logic [PTRW-1:0] n);
    logic [PTRW:0] s;
    s = {1'b0, p} + {1'b0, n};
    if (s >= WRAP_X) s = s - WRAP_X;
    return s[PTRW-1:0];
  endfunction

  // Storage index of a pointer.
  function automatic logic [IW-1:0] ptr_idx(input logic [PTRW-1:0] p);
    logic [PTRW:0] s;
    s = {1'b0, p};
    if (s >= DEPTH_X) s = s - DEPTH_X;
    return s[IW-1:0];
  endfunction

  // Distance a - b in pointer space (modulo 2*FREE_DEPTH).
  function automatic logic [PTRW-1:0] ptr_dist(input logic [PTRW-1:0] a,
                                                input logic [PTRW-1:0] b);
    logic [PTRW:0] s;
    s = {1'b0, a} + WRAP_X - {1'b0, b};
    if (s >= WRAP_X) s = s - WRAP_X;
    return s[PTRW-1:0];
  endfunction

  logic [PRW-1:0]          list_q [FREE_DEPTH];
  logic [PTRW-1:0]         rd_q, rd_d;
  logic [PTRW-1:0]         wr_q, wr_d;
  logic [PTRW-1:0]         cmt_q, cmt_d;
  logic [CNTW-1:0]         free_cnt_q, free_cnt_d;

  logic [RENAME_WIDTH-1:0] need;
  logic [CW-1:0]           n_need;
  logic [CW-1:0]           lane_off [RENAME_WIDTH];
  logic [PRW-1:0]          lane_id  [RENAME_WIDTH];
  logic [MW-1:0]           m_rel;
  logic [IW-1:0]           rel_idx  [COMMIT_WIDTH];
  logic                    fire;

  // Lane offsets into the list and the release write slots.
  // NOTE: always_comb uses blocking '=' so the running popcount is read back
  // within the same pass; clocked state below uses non-blocking '<='.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave a value held, which would infer a latch.
    need   = '0;
    n_need = '0;
    m_rel  = '0;
    for (int k = 0; k < RENAME_WIDTH; k++) begin
      need[k]     = alloc_req_vld[k] & alloc_req_rd_en[k] &
                    (alloc_req_arch_id[k*AW +: AW] != '0);
      lane_off[k] = n_need;
      if (need[k]) n_need = n_need + 1'b1;
      lane_id[k]  = list_q[ptr_idx(ptr_add(rd_q, PTRW'(lane_off[k])))];
    end
    for (int j = 0; j < COMMIT_WIDTH; j++) begin
      rel_idx[j] = ptr_idx(ptr_add(wr_q, PTRW'(m_rel)));
      if (commit_rd_en[j]) m_rel = m_rel + 1'b1;
    end

    // Releases only reach free_cnt_q next cycle, so they never fund a grant
    // in the cycle they arrive.
    alloc_rdy      = ~rst & ~cancel_en & (free_cnt_q >= CNTW'(n_need));
    fire           = alloc_rdy & (|alloc_req_vld);
    cancel_edge_en = ~rst & cancel_en;

    cmt_d = ptr_add(cmt_q, PTRW'(m_rel));
    wr_d  = ptr_add(wr_q, PTRW'(m_rel));
    if (cancel_en)  rd_d = cmt_d;  // same-cycle commits land before the rewind
    else if (fire)  rd_d = ptr_add(rd_q, PTRW'(n_need));
    else            rd_d = rd_q;
    free_cnt_d = CNTW'(ptr_dist(wr_d, rd_d));
  end

  // Map-entry write strobes. Lanes are scanned low to high, so the highest
  // lane targeting an arch reg overwrites the ID of any lower lane.
  always_comb begin
    alloc_phy_id       = '0;
    reg_rd_en          = '0;
    reg_rd_allocate_id = '0;
    for (int k = 0; k < RENAME_WIDTH; k++) begin
      alloc_phy_id[k*PRW +: PRW] = lane_id[k];
      if (fire && need[k]) begin
        reg_rd_en[alloc_req_arch_id[k*AW +: AW]] = 1'b1;
        reg_rd_allocate_id[int'(alloc_req_arch_id[k*AW +: AW])*PRW +: PRW] = lane_id[k];
      end
    end
  end

  // NOTE: the list array is reset along with the pointers. Arch 0 is not
  // hardwired to anything other than its own ID, so IDs ARCH_REG_NUM and up
  // must be seeded into the list.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q       <= '0;
      cmt_q      <= '0;
      wr_q       <= PTRW'(FREE_DEPTH);
      free_cnt_q <= CNTW'(FREE_DEPTH);
      for (int i = 0; i < FREE_DEPTH; i++) list_q[i] <= PRW'(ARCH_REG_NUM + i);
    end else begin
      rd_q       <= rd_d;
      cmt_q      <= cmt_d;
      wr_q       <= wr_d;
      free_cnt_q <= free_cnt_d;
      for (int j = 0; j < COMMIT_WIDTH; j++) begin
        if (commit_rd_en[j]) list_q[rel_idx[j]] <= commit_old_phy_id[j*PRW +: PRW];
      end
    end
  end

  assign free_cnt = free_cnt_q;

  // Releasing more IDs than are outstanding would overflow the list.
  a_free_cnt_bound: assert property (@(posedge clk) disable iff (rst)
    free_cnt_q <= CNTW'(FREE_DEPTH));
  // The read pointer never runs ahead of the write pointer.
  a_rd_behind_wr: assert property (@(posedge clk) disable iff (rst)
    ptr_dist(wr_q, rd_q) <= PTRW'(FREE_DEPTH));
  // The commit pointer trails the read pointer and starts at the last restore
  // point, because a cancel moves rd_ptr onto it.
  a_cmt_behind_rd: assert property (@(posedge clk) disable iff (rst)
    ptr_dist(rd_q, cmt_q) <= PTRW'(FREE_DEPTH));

endmodule

// File: tb/tb_toy_rename_alloc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_toy_rename_alloc_ctrl
//
// Scoreboard bench. The driver computes each cycle's expected response from a
// queue-based reference model and pushes it. A monitor on the falling edge
// pops that entry and compares it with the DUT outputs.
//
// The reference model keeps three pieces of state:
//   - free_ids: the allocatable IDs, in order.
//   - infl_q:   the speculative (uncommitted) grants, in order.
//   - cmap:     the committed arch -> phy map.
// A commit retires the oldest grant and releases the ID it superseded.
// A cancel puts the uncommitted grants back at the front of the free order.
// -----------------------------------------------------------------------------
module tb_toy_rename_alloc_ctrl;

  localparam int RW   = 4;
  localparam int CWD  = 4;
  localparam int ARCH = 32;
  localparam int PRW  = 7;
  localparam int AW   = 5;
  localparam int FREE = 96;

  logic                  clk;
  logic                  rst;
  logic [RW-1:0]         alloc_req_vld;
  logic [RW-1:0]         alloc_req_rd_en;
  logic [RW*AW-1:0]      alloc_req_arch_id;
  logic                  alloc_rdy;
  logic [RW*PRW-1:0]     alloc_phy_id;
  logic [ARCH-1:0]       reg_rd_en;
  logic [ARCH*PRW-1:0]   reg_rd_allocate_id;
  logic                  cancel_en;
  logic                  cancel_edge_en;
  logic [CWD-1:0]        commit_rd_en;
  logic [CWD*PRW-1:0]    commit_old_phy_id;
  logic [PRW:0]          free_cnt;

  toy_rename_alloc_ctrl dut (
    .clk                (clk),
    .rst                (rst),
    .alloc_req_vld      (alloc_req_vld),
    .alloc_req_rd_en    (alloc_req_rd_en),
    .alloc_req_arch_id  (alloc_req_arch_id),
    .alloc_rdy          (alloc_rdy),
    .alloc_phy_id       (alloc_phy_id),
    .reg_rd_en          (reg_rd_en),
    .reg_rd_allocate_id (reg_rd_allocate_id),
    .cancel_en          (cancel_en),
    .cancel_edge_en     (cancel_edge_en),
    .commit_rd_en       (commit_rd_en),
    .commit_old_phy_id  (commit_old_phy_id),
    .free_cnt           (free_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic                chk_free;
    logic                rdy;
    logic                cedge;
    logic [PRW:0]        free;
    logic [RW-1:0]       id_mask;
    logic [RW*PRW-1:0]   ids;
    logic [ARCH-1:0]     ren;
    logic [ARCH*PRW-1:0] aid;
  } exp_t;

  typedef struct packed {
    logic [AW-1:0]  arch;
    logic [PRW-1:0] id;
  } infl_t;

  exp_t           exp_q[$];
  logic [PRW-1:0] free_ids[$];
  infl_t          infl_q[$];
  logic [PRW-1:0] cmap [ARCH];
  int             checks   = 0;
  int             failures = 0;

  task automatic check(input string name, input logic [ARCH*PRW-1:0] act,
                       input logic [ARCH*PRW-1:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Monitor: compares one scoreboard entry per cycle, away from the rising edge.
  exp_t mon_e;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("alloc_rdy", ARCH*PRW'(alloc_rdy), ARCH*PRW'(mon_e.rdy));
      check("cancel_edge_en", ARCH*PRW'(cancel_edge_en), ARCH*PRW'(mon_e.cedge));
      check("reg_rd_en", ARCH*PRW'(reg_rd_en), ARCH*PRW'(mon_e.ren));
      if (mon_e.chk_free) check("free_cnt", ARCH*PRW'(free_cnt), ARCH*PRW'(mon_e.free));
      for (int k = 0; k < RW; k++) begin
        if (mon_e.id_mask[k])
          check($sformatf("alloc_phy_id[%0d]", k), ARCH*PRW'(alloc_phy_id[k*PRW +: PRW]),
                ARCH*PRW'(mon_e.ids[k*PRW +: PRW]));
      end
      for (int a = 0; a < ARCH; a++) begin
        if (mon_e.ren[a])
          check($sformatf("reg_rd_allocate_id[%0d]", a),
                ARCH*PRW'(reg_rd_allocate_id[a*PRW +: PRW]),
                ARCH*PRW'(mon_e.aid[a*PRW +: PRW]));
      end
    end
  end

  function automatic logic [RW*AW-1:0] pack_arch(input int a0, input int a1,
                                                 input int a2, input int a3);
    return {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endfunction

  task automatic model_reset();
    free_ids.delete();
    infl_q.delete();
    for (int i = 0; i < FREE; i++) free_ids.push_back(PRW'(ARCH + i));
    for (int a = 0; a < ARCH; a++) cmap[a] = PRW'(a);
  endtask

  // One reset cycle. All inputs are active so that zero outputs really come from rst.
  task automatic reset_cycle(input logic chk_free, input logic cancel);
    exp_t e;
    @(posedge clk); #1;
    rst               = 1'b1;
    alloc_req_vld     = '1;
    alloc_req_rd_en   = '1;
    alloc_req_arch_id = pack_arch(1, 2, 3, 4);
    cancel_en         = cancel;
    commit_rd_en      = '0;
    commit_old_phy_id = '0;
    e          = '0;
    e.chk_free = chk_free;
    e.free     = (PRW+1)'(free_ids.size());
    exp_q.push_back(e);
  endtask

  task automatic do_reset(input logic first);
    reset_cycle(~first, 1'b1);
    model_reset();
    reset_cycle(1'b1, 1'b0);
  endtask

  // One operating cycle: drive inputs, push the expected response, advance the model.
  task automatic step(input logic [RW-1:0] vld, input logic [RW-1:0] rde,
                      input logic [RW*AW-1:0] arch, input logic cancel,
                      input logic [CWD-1:0] cmask);
    exp_t           e;
    logic [CWD-1:0] cm;
    logic [CWD*PRW-1:0] cids;
    logic [PRW-1:0] released[$];
    infl_t          grants[$];
    infl_t          h;
    int             n, idx, avail;
    logic           nd, fire;
    logic [AW-1:0]  a;

    @(posedge clk); #1;
    // Commits retire the oldest outstanding grants and never more than exist.
    cm    = cmask;
    avail = infl_q.size();
    cids  = '0;
    for (int j = 0; j < CWD; j++) begin
      if (cm[j] && avail > 0) begin
        avail--;
        h = infl_q.pop_front();
        cids[j*PRW +: PRW] = cmap[h.arch];
        released.push_back(cmap[h.arch]);
        cmap[h.arch] = h.id;
      end else begin
        cm[j] = 1'b0;
      end
    end

    rst               = 1'b0;
    alloc_req_vld     = vld;
    alloc_req_rd_en   = rde;
    alloc_req_arch_id = arch;
    cancel_en         = cancel;
    commit_rd_en      = cm;
    commit_old_phy_id = cids;

    n = 0;
    for (int k = 0; k < RW; k++)
      if (vld[k] && rde[k] && arch[k*AW +: AW] != '0) n++;
    e          = '0;
    e.chk_free = 1'b1;
    e.free     = (PRW+1)'(free_ids.size());
    e.cedge    = cancel;
    e.rdy      = !cancel && (free_ids.size() >= n);
    fire       = e.rdy && (|vld);
    if (fire) begin
      idx = 0;
      for (int k = 0; k < RW; k++) begin
        a  = arch[k*AW +: AW];
        nd = vld[k] && rde[k] && a != '0;
        if (nd) begin
          e.id_mask[k]             = 1'b1;
          e.ids[k*PRW +: PRW]      = free_ids[idx];
          e.ren[a]                 = 1'b1;
          e.aid[int'(a)*PRW +: PRW] = free_ids[idx];
          grants.push_back({a, free_ids[idx]});
          idx++;
        end
      end
    end
    exp_q.push_back(e);

    // Advance the model to the state after this edge.
    foreach (grants[i]) begin
      void'(free_ids.pop_front());
      infl_q.push_back(grants[i]);
    end
    foreach (released[i]) free_ids.push_back(released[i]);
    if (cancel) begin
      for (int i = infl_q.size() - 1; i >= 0; i--) free_ids.push_front(infl_q[i].id);
      infl_q.delete();
    end
  endtask

  task automatic idle();
    step('0, '0, '0, 1'b0, '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [RW*AW-1:0] ar;
    logic [CWD-1:0]   cm;

    rst               = 1'b1;
    alloc_req_vld     = '0;
    alloc_req_rd_en   = '0;
    alloc_req_arch_id = '0;
    cancel_en         = 1'b0;
    commit_rd_en      = '0;
    commit_old_phy_id = '0;
    model_reset();

    // Scenario 1: four destinations right after reset.
    do_reset(1'b1);
    step(4'hF, 4'hF, pack_arch(1, 2, 3, 4), 1'b0, '0);
    idle();

    // Scenario 2: duplicate arch 5 on lanes 0 and 2, arch 0 on lane 1.
    do_reset(1'b0);
    step(4'b0111, 4'b0111, pack_arch(5, 0, 5, 0), 1'b0, '0);
    idle();

    // Scenario 3: drain to 2, reject 3, grant 2, reject at empty.
    repeat (23) step(4'hF, 4'hF, pack_arch(1, 2, 3, 4), 1'b0, '0);
    step(4'b0111, 4'b0111, pack_arch(6, 7, 8, 0), 1'b0, '0);
    step(4'b0011, 4'b0011, pack_arch(6, 7, 0, 0), 1'b0, '0);
    step(4'b0001, 4'b0001, pack_arch(9, 0, 0, 0), 1'b0, '0);
    idle();

    // Scenario 4: allocate 8, commit 3, cancel with a live request, reallocate.
    do_reset(1'b0);
    step(4'hF, 4'hF, pack_arch(1, 2, 3, 4), 1'b0, '0);
    step(4'hF, 4'hF, pack_arch(5, 6, 7, 8), 1'b0, '0);
    step('0, '0, '0, 1'b0, 4'b0111);
    step(4'hF, 4'hF, pack_arch(9, 10, 11, 12), 1'b1, '0);
    idle();
    step(4'b0001, 4'b0001, pack_arch(13, 0, 0, 0), 1'b0, '0);

    // Scenario 5: cancel together with two commits.
    step(4'hF, 4'hF, pack_arch(1, 2, 3, 4), 1'b0, '0);
    step(4'hF, 4'hF, pack_arch(5, 6, 7, 8), 1'b0, '0);
    step(4'hF, 4'hF, pack_arch(9, 10, 11, 12), 1'b1, 4'b0101);
    idle();
    step(4'hF, 4'hF, pack_arch(14, 15, 16, 17), 1'b0, '0);
    step(4'hF, 4'hF, pack_arch(18, 19, 20, 21), 1'b0, '0);

    // Scenario 6: free=1, a release of 4 does not fund a same-cycle request of 2.
    do_reset(1'b0);
    repeat (23) step(4'hF, 4'hF, pack_arch(1, 2, 3, 4), 1'b0, '0);
    step(4'b0111, 4'b0111, pack_arch(5, 6, 7, 0), 1'b0, '0);
    step(4'b0011, 4'b0011, pack_arch(8, 9, 0, 0), 1'b0, 4'hF);
    step(4'b0011, 4'b0011, pack_arch(8, 9, 0, 0), 1'b0, '0);
    idle();

    // Randomised traffic, with occasional mid-operation resets.
    do_reset(1'b0);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset(1'b0);
      end else begin
        for (int k = 0; k < RW; k++)
          ar[k*AW +: AW] = ($urandom_range(0, 2) == 0) ? AW'($urandom_range(0, 3))
                                                       : AW'($urandom_range(0, ARCH - 1));
        cm = CWD'($urandom) & CWD'($urandom);
        step(RW'($urandom), RW'($urandom) | RW'($urandom), ar,
             ($urandom_range(0, 19) == 0), cm);
      end
    end
    idle();

    @(posedge clk);
    @(posedge clk);
    check("scoreboard_drained", ARCH*PRW'(exp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
